// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the button conditioner bank.
package button_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HELD   = 2'd1,
        S_REPEAT = 2'd2
    } btn_state_t;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val == 0) ? 32'd1 : 32'($clog2(max_val + 1));
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchroniser, debounce counter and a press/release/repeat
// event FSM producing a registered one-cycle pulse.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter bit          FIRE_ON_REL  = 1'b0,
    parameter int unsigned REPEAT_DELAY = 0,
    parameter int unsigned REPEAT_RATE  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic repeat_en,
    output logic level,
    output logic pulse
);

    localparam int unsigned CNT_W    = cnt_w(DEBOUNCE_CYC);
    localparam int unsigned RCNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RCNT_W   = cnt_w(RCNT_MAX);
    localparam bit          REPEAT_ON = (REPEAT_DELAY != 0) && !FIRE_ON_REL;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [RCNT_W-1:0] R_DELAY  = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] R_RATE   = RCNT_W'(REPEAT_RATE);

    logic              sync1;
    logic              sync2;
    logic [CNT_W-1:0]  cnt;
    btn_state_t        state;
    btn_state_t        state_next;
    logic [RCNT_W-1:0] rcnt;
    logic [RCNT_W-1:0] rcnt_next;
    logic              pulse_next;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYC consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Event FSM registers; the pulse is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            rcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_next;
            rcnt  <= rcnt_next;
            pulse <= pulse_next;
        end
    end

    always_comb begin
        state_next = state;
        rcnt_next  = rcnt;
        pulse_next = 1'b0;
        case (state)
            S_IDLE: begin
                rcnt_next = '0;
                if (level) begin
                    state_next = S_HELD;
                    pulse_next = !FIRE_ON_REL;
                end
            end
            S_HELD: begin
                if (!level) begin
                    state_next = S_IDLE;
                    pulse_next = FIRE_ON_REL;
                    rcnt_next  = '0;
                end else if (!REPEAT_ON || !repeat_en) begin
                    rcnt_next = '0;
                end else if (rcnt == R_DELAY) begin
                    state_next = S_REPEAT;
                    pulse_next = 1'b1;
                    rcnt_next  = '0;
                end else if (rcnt != '1) begin
                    rcnt_next = rcnt + RCNT_W'(1);
                end
            end
            S_REPEAT: begin
                // A release ends repeating silently; dropping repeat_en rearms the full delay.
                if (!level) begin
                    state_next = S_IDLE;
                    rcnt_next  = '0;
                end else if (!repeat_en) begin
                    state_next = S_HELD;
                    rcnt_next  = '0;
                end else if (rcnt == R_RATE) begin
                    pulse_next = 1'b1;
                    rcnt_next  = '0;
                end else if (rcnt != '1) begin
                    rcnt_next = rcnt + RCNT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                rcnt_next  = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_pulse_bank.sv
// Bank of independent button conditioners turning raw bouncy levels into clean
// debounced levels and one-cycle event pulses.
module button_pulse_bank
    import button_pkg::*;
#(
    parameter int unsigned      N_BTN        = 4,
    parameter int unsigned      DEBOUNCE_CYC = 16,
    parameter logic [N_BTN-1:0] FIRE_ON_REL  = '0,
    parameter int unsigned      REPEAT_DELAY = 0,
    parameter int unsigned      REPEAT_RATE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    // Each channel gets its own press/release mode bit.
    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .FIRE_ON_REL  (FIRE_ON_REL[i]),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .btn       (btn_in[i]),
            .repeat_en (repeat_en),
            .level     (btn_level[i]),
            .pulse     (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_pulse_bank.sv
// Self-checking bench for button_pulse_bank: hand-derived vector table, multi-cycle
// repeat sequences and a long randomized run against a behavioural model.
module tb_button_pulse_bank;

    localparam int N     = 2;
    localparam int DEB   = 4;
    localparam int RDLY  = 10;
    localparam int RRATE = 3;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic [N-1:0] btn_in    = '0;
    logic         repeat_en = 1'b0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;

    always #5 clk = ~clk;

    button_pulse_bank #(
        .N_BTN        (N),
        .DEBOUNCE_CYC (DEB),
        .FIRE_ON_REL  (2'b10),
        .REPEAT_DELAY (RDLY),
        .REPEAT_RATE  (RRATE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .repeat_en (repeat_en),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [N-1:0] rel_mask = 2'b10;

    // Reference model: pin history, accepted level, held flag and repeat timing.
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_pulse = '0;
    logic [15:0]  m_hist[N];
    bit           m_held[N];
    int           m_since[N];
    int           m_nrep[N];

    typedef struct {
        logic         rst;
        logic [N-1:0] btn;
        logic         ren;
        logic [N-1:0] lvl;
        logic [N-1:0] pls;
    } vec_t;
    vec_t vq[$];

    int pq[$];
    int exp_rep[$]  = '{7, 18, 22, 26, 30, 34, 38, 42};
    int exp_drop[$] = '{7, 18, 22, 36, 40, 44, 48, 52};

    int           left[N];
    logic [N-1:0] rb;
    logic         ren;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge of the model, from the inputs present before that edge.
    task automatic model_edge(input logic r, input logic [N-1:0] b, input logic en);
        for (int ch = 0; ch < N; ch++) begin
            if (r) begin
                m_level[ch] = 1'b0;
                m_pulse[ch] = 1'b0;
                m_hist[ch]  = '0;
                m_held[ch]  = 0;
                m_since[ch] = 0;
                m_nrep[ch]  = 0;
            end else begin
                logic p;
                logic want;
                p = 1'b0;
                if (!m_held[ch] && m_level[ch]) begin
                    m_held[ch]  = 1;
                    p           = !rel_mask[ch];
                    m_since[ch] = 0;
                    m_nrep[ch]  = 0;
                end else if (m_held[ch] && !m_level[ch]) begin
                    m_held[ch] = 0;
                    p          = rel_mask[ch];
                end else if (m_held[ch] && !rel_mask[ch]) begin
                    if (!en) begin
                        m_since[ch] = 0;
                        m_nrep[ch]  = 0;
                    end else begin
                        m_since[ch]++;
                        if (m_since[ch] == ((m_nrep[ch] == 0) ? RDLY : RRATE) + 1) begin
                            p           = 1'b1;
                            m_since[ch] = 0;
                            m_nrep[ch]++;
                        end
                    end
                end
                // Bits [DEB:1] are the synchronised samples seen on the last DEB edges.
                want = !m_level[ch];
                if (m_hist[ch][DEB:1] == {DEB{want}}) m_level[ch] = want;
                m_hist[ch]  = {m_hist[ch][14:0], b[ch]};
                m_pulse[ch] = p;
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] b, input logic en);
        @(negedge clk);
        reset     = r;
        btn_in    = b;
        repeat_en = en;
        @(posedge clk);
        model_edge(r, b, en);
        #1;
        cyc = r ? 0 : cyc + 1;
        check("model_level", btn_level, m_level);
        check("model_pulse", btn_pulse, m_pulse);
    endtask

    task automatic addv(input int n, input logic r, input logic [N-1:0] b, input logic en,
                        input logic [N-1:0] l, input logic [N-1:0] p);
        vec_t v;
        v.rst = r; v.btn = b; v.ren = en; v.lvl = l; v.pls = p;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    task automatic compare_queue(input string name, input int act[$], input int exp[$]);
        check_int({name, "_count"}, act.size(), exp.size());
        for (int i = 0; i < act.size() && i < exp.size(); i++)
            check_int({name, "_cycle"}, act[i], exp[i]);
    endtask

    initial begin
        for (int ch = 0; ch < N; ch++) begin
            m_hist[ch] = '0; m_held[ch] = 0; m_since[ch] = 0; m_nrep[ch] = 0; left[ch] = 0;
        end

        // Reset with both held, then both debounce together; mode decides who pulses.
        addv(3, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00);
        addv(5, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00);
        addv(1, 1'b0, 2'b11, 1'b0, 2'b11, 2'b00);
        addv(1, 1'b0, 2'b11, 1'b0, 2'b11, 2'b01);
        addv(1, 1'b0, 2'b11, 1'b0, 2'b11, 2'b00);
        addv(5, 1'b0, 2'b00, 1'b0, 2'b11, 2'b00);
        addv(1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        addv(1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10);
        addv(1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].btn, vq[i].ren);
            check("vec_level", btn_level, vq[i].lvl);
            check("vec_pulse", btn_pulse, vq[i].pls);
        end

        // Bounce 1,0,1,0 on ch0 must never be accepted.
        step(1'b1, 2'b00, 1'b0);
        for (int c = 0; c < 16; c++) begin
            step(1'b0, (c < 4 && c % 2 == 0) ? 2'b01 : 2'b00, 1'b0);
            check("glitch_level", {1'b0, btn_level[0]}, 2'b00);
            check("glitch_pulse", {1'b0, btn_pulse[0]}, 2'b00);
        end

        // Hold-to-repeat on ch0, released before the next repeat would fall due.
        step(1'b1, 2'b00, 1'b1);
        pq.delete();
        for (int c = 1; c <= 60; c++) begin
            step(1'b0, (c <= 39) ? 2'b01 : 2'b00, 1'b1);
            if (btn_pulse[0]) pq.push_back(cyc);
        end
        compare_queue("repeat", pq, exp_rep);

        // repeat_en dropped for two cycles mid-repeat restarts the full delay.
        step(1'b1, 2'b00, 1'b1);
        pq.delete();
        for (int c = 1; c <= 55; c++) begin
            step(1'b0, 2'b01, !(c == 24 || c == 25));
            if (btn_pulse[0]) pq.push_back(cyc);
        end
        compare_queue("drop", pq, exp_drop);
        for (int c = 0; c < 10; c++) step(1'b0, 2'b00, 1'b0);

        // Randomized run: glitches, short presses and long holds, with rare resets.
        step(1'b1, 2'b00, 1'b1);
        rb  = '0;
        ren = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (left[ch] == 0) begin
                    rb[ch] = ~rb[ch];
                    case ($urandom_range(0, 3))
                        0:       left[ch] = int'($urandom_range(1, 3));
                        1:       left[ch] = int'($urandom_range(4, 12));
                        default: left[ch] = int'($urandom_range(15, 45));
                    endcase
                end else begin
                    left[ch]--;
                end
            end
            if ($urandom_range(0, 99) == 0) ren = ~ren;
            step($urandom_range(0, 799) == 0, rb, ren);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
